miner_job_master: RTL

//  Avalon-MM master that loads one mining job into the miner's CSR slave and retrieves the result.

---
 rtl/miner_job_master.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/miner_job_master.sv
// Avalon-MM master: loads one job into the miner CSR slave, polls status, returns nonce.
// Ports: clk/n_rst, job_* (valid/ready in), result_* (valid/ready out), m_* Avalon master.
module miner_job_master #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'hFF_FFFF,
   parameter logic [4:0]  STATUS_ADDR    = 5'd1,
   parameter logic [4:0]  NONCE_ADDR     = 5'd2
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         job_valid,
   output logic         job_ready,
   input  logic [255:0] job_target,
   input  logic [407:0] job_msg,
   output logic         result_valid,
   input  logic         result_ready,
   output logic         result_found,
   output logic [31:0]  result_nonce,
   output logic [4:0]   m_address,
   output logic [31:0]  m_writedata,
   output logic         m_write,
   output logic         m_read,
   output logic         m_chipselect,
   input  logic [31:0]  m_readdata
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      CLR      = 4'd1,
      WR_TGT   = 4'd2,
      WR_MSG   = 4'd3,
      SET      = 4'd4,
      POLL     = 4'd5,
      POLL_W   = 4'd6,
      RD_NONCE = 4'd7,
      NONCE_W  = 4'd8,
      DONE     = 4'd9
   } state_t;

   state_t         state;
   logic [255:0]   tgtReg;
   logic [407:0]   msgReg;
   logic [3:0]     beat;
   logic [23:0]    toCnt;
   logic [3:0]     nxtBeat;
   logic [415:0]   msgPad;
   logic [31:0]    tgtWord;
   logic [31:0]    msgWord;
   logic [23:0]    toCntInc;

   // Bus outputs are registered together with the state, so the beat
   // loaded on a transition is the one visible during the new state.
   assign nxtBeat  = beat + 4'd1;
   // Message padded by one zero byte so every register is a 32-bit slice.
   assign msgPad   = {msgReg, 8'h00};
   assign tgtWord  = tgtReg[{nxtBeat[2:0], 5'd0} +: 32];
   assign msgWord  = msgPad[{nxtBeat, 5'd0} +: 32];
   assign toCntInc = (toCnt == 24'hFF_FFFF) ? toCnt : toCnt + 24'd1;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state        <= IDLE;
         tgtReg       <= '0;
         msgReg       <= '0;
         beat         <= '0;
         toCnt        <= '0;
         job_ready    <= 1'b1;
         result_valid <= 1'b0;
         result_found <= 1'b0;
         result_nonce <= '0;
         m_address    <= '0;
         m_writedata  <= '0;
         m_write      <= 1'b0;
         m_read       <= 1'b0;
         m_chipselect <= 1'b0;
      end else begin
         m_address    <= '0;
         m_writedata  <= '0;
         m_write      <= 1'b0;
         m_read       <= 1'b0;
         m_chipselect <= 1'b0;
         case (state)
            IDLE: begin
               if (job_valid) begin
                  tgtReg       <= job_target;
                  msgReg       <= job_msg;
                  job_ready    <= 1'b0;
                  state        <= CLR;
                  m_write      <= 1'b1;
                  m_chipselect <= 1'b1;
               end
            end
            CLR: begin
               state        <= WR_TGT;
               beat         <= '0;
               m_address    <= 5'd16;
               m_writedata  <= tgtReg[31:0];
               m_write      <= 1'b1;
               m_chipselect <= 1'b1;
            end
            WR_TGT: begin
               m_write      <= 1'b1;
               m_chipselect <= 1'b1;
               if (beat == 4'd7) begin
                  state       <= WR_MSG;
                  beat        <= '0;
                  m_address   <= 5'd3;
                  m_writedata <= msgPad[31:0];
               end else begin
                  beat        <= nxtBeat;
                  m_address   <= 5'd16 + {2'b00, nxtBeat[2:0]};
                  m_writedata <= tgtWord;
               end
            end
            WR_MSG: begin
               m_write      <= 1'b1;
               m_chipselect <= 1'b1;
               if (beat == 4'd12) begin
                  state       <= SET;
                  beat        <= '0;
                  m_writedata <= 32'h3;
               end else begin
                  beat        <= nxtBeat;
                  m_address   <= 5'd3 + {1'b0, nxtBeat};
                  m_writedata <= msgWord;
               end
            end
            SET: begin
               toCnt        <= '0;
               state        <= POLL;
               m_address    <= STATUS_ADDR;
               m_read       <= 1'b1;
               m_chipselect <= 1'b1;
            end
            POLL: begin
               toCnt <= toCntInc;
               state <= POLL_W;
            end
            POLL_W: begin
               toCnt <= toCntInc;
               // Found wins over a timeout reached in the same cycle.
               if (m_readdata[1]) begin
                  state        <= RD_NONCE;
                  m_address    <= NONCE_ADDR;
                  m_read       <= 1'b1;
                  m_chipselect <= 1'b1;
               end else if (toCnt >= TIMEOUT_CYCLES) begin
                  state        <= DONE;
                  result_valid <= 1'b1;
                  result_found <= 1'b0;
                  result_nonce <= '0;
               end else begin
                  state        <= POLL;
                  m_address    <= STATUS_ADDR;
                  m_read       <= 1'b1;
                  m_chipselect <= 1'b1;
               end
            end
            RD_NONCE: state <= NONCE_W;
            NONCE_W: begin
               state        <= DONE;
               result_valid <= 1'b1;
               result_found <= 1'b1;
               result_nonce <= m_readdata;
            end
            DONE: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  job_ready    <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
